// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, LSB-first, optional parity, M_STOP stop bits.
// Define UART_RX_SYNC_EN to add a two-flop synchronizer on i_data (adds 2 clocks of latency).
// Without it, i_data must already be synchronous to i_clock.
module uart_rx #(
    parameter int unsigned NB_DATA         = 8,
    parameter int unsigned N_DATA          = 8,
    parameter int unsigned PARITY_CHECK    = 1,
    parameter int unsigned EVEN_ODD_PARITY = 1,
    parameter int unsigned M_STOP          = 1,
    parameter int unsigned OVERSAMPLE      = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic               i_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_parity_err,
    output logic               o_frame_err
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(N_DATA + 1);
    localparam int unsigned STOP_W = $clog2(M_STOP + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N_DATA - 1);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(M_STOP - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state_q;
    logic [TICK_W-1:0]   tick_q;
    logic [BIT_W-1:0]    bit_q;
    logic [STOP_W-1:0]   stop_q;
    logic [N_DATA-1:0]   shift_q;
    logic                perr_q;
    logic                ferr_q;
    logic                rx_line;
    logic                par_exp;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_data};
        end
    end

    assign rx_line = sync_q[1];
`else
    assign rx_line = i_data;
`endif

    // Parity expected from the fully assembled data word.
    assign par_exp = (EVEN_ODD_PARITY != 0) ? (^shift_q) : (~^shift_q);

    // Receive FSM: counters advance only on i_valid; outputs load together on done.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            stop_q       <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            o_data       <= '0;
            o_rx_done    <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            if (i_valid) begin
                case (state_q)
                    IDLE: begin
                        if (!rx_line) begin
                            tick_q  <= '0;
                            state_q <= START;
                        end
                    end

                    START: begin
                        if (tick_q == TICK_MID) begin
                            tick_q <= '0;
                            if (!rx_line) begin
                                bit_q   <= '0;
                                stop_q  <= '0;
                                perr_q  <= 1'b0;
                                ferr_q  <= 1'b0;
                                state_q <= DATA;
                            end else begin
                                // Start bit did not hold through mid-bit: a glitch.
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end

                    DATA: begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            shift_q <= {rx_line, shift_q[N_DATA-1:1]};
                            if (bit_q == BIT_LAST) begin
                                bit_q   <= '0;
                                state_q <= (PARITY_CHECK != 0) ? PARITY : STOP;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end

                    PARITY: begin
                        if (tick_q == TICK_LAST) begin
                            tick_q  <= '0;
                            perr_q  <= (rx_line != par_exp);
                            state_q <= STOP;
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end

                    STOP: begin
                        if (tick_q == TICK_LAST) begin
                            tick_q <= '0;
                            if (!rx_line) begin
                                ferr_q <= 1'b1;
                            end
                            if (stop_q == STOP_LAST) begin
                                stop_q       <= '0;
                                state_q      <= IDLE;
                                o_rx_done    <= 1'b1;
                                o_data       <= NB_DATA'(shift_q);
                                o_parity_err <= (PARITY_CHECK != 0) ? perr_q : 1'b0;
                                o_frame_err  <= ferr_q | ~rx_line;
                            end else begin
                                stop_q <= stop_q + STOP_W'(1);
                            end
                        end else begin
                            tick_q <= tick_q + TICK_W'(1);
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with default parameters (8E1, 16 ticks/bit).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic       line;
    logic [7:0] data;
    logic       done;
    logic       perr;
    logic       ferr;

    always #5 clk = ~clk;

    uart_rx dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_valid      (valid),
        .i_data       (line),
        .o_data       (data),
        .o_rx_done    (done),
        .o_parity_err (perr),
        .o_frame_err  (ferr)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic        perr;
        logic        ferr;
        logic [31:0] tick;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned n_cmp    = 0;
    int unsigned n_bad    = 0;
    int unsigned tick_no  = 0;
    int unsigned done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // One baud x OVERSAMPLE tick: line updated with the one-clock valid pulse, then 3 idle clocks.
    task automatic do_tick(input logic lvl);
        @(negedge clk);
        line  = lvl;
        valid = 1'b1;
        tick_no++;
        @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b1);
    endtask

    // Full frame: start, 8 data LSB-first, parity (optionally inverted), one stop bit.
    task automatic send_frame(input logic [7:0] d, input logic par_flip,
                              input logic stop_v, input int freeze_at);
        logic [10:0] bits;
        exp_t        e;
        bits   = {stop_v, (^d) ^ par_flip, d, 1'b0};
        e.data = d;
        e.perr = par_flip;
        e.ferr = ~stop_v;
        e.tick = tick_no + 32'd1 + 32'd168;
        exp_q.push_back(e);
        for (int k = 0; k < 11; k++) begin
            for (int t = 0; t < 16; t++) begin
                do_tick(bits[k]);
                if (k * 16 + t == freeze_at) repeat (50) @(negedge clk);
            end
        end
        idle_ticks(24);
    endtask

    // Scoreboard: every done pulse pops and compares one expected frame.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_data", 32'(data), 32'(mon_e.data));
                check("done_perr", 32'(perr), 32'(mon_e.perr));
                check("done_ferr", 32'(ferr), 32'(mon_e.ferr));
                check("done_tick", 32'(tick_no), mon_e.tick);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [9:0]  saved;
        int unsigned cnt;
        logic [7:0]  pd;
        exp_t        e;

        rst_n = 1'b0;
        valid = 1'b0;
        line  = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_data", 32'(data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_perr", 32'(perr), 32'd0);
        check("rst_ferr", 32'(ferr), 32'd0);
        rst_n = 1'b1;
        idle_ticks(5);

        send_frame(8'hA5, 1'b0, 1'b1, -1);
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        send_frame(8'h81, 1'b0, 1'b0, -1);
        send_frame(8'h55, 1'b0, 1'b1, -1);

        // Short low pulse must be rejected as a glitch.
        saved = {data, perr, ferr};
        cnt   = done_cnt;
        for (int i = 0; i < 4; i++) do_tick(1'b0);
        idle_ticks(30);
        check("glitch_done_cnt", 32'(done_cnt), 32'(cnt));
        check("glitch_outputs", 32'({data, perr, ferr}), 32'(saved));

        // Reset in the middle of the data bits discards the partial frame.
        pd = 8'h11;
        for (int t = 0; t < 16; t++) do_tick(1'b0);
        for (int k = 0; k < 3; k++)
            for (int t = 0; t < 16; t++) do_tick(pd[k]);
        @(negedge clk);
        line  = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_perr", 32'(perr), 32'd0);
        check("midrst_ferr", 32'(ferr), 32'd0);
        rst_n = 1'b1;
        cnt   = done_cnt;
        idle_ticks(30);
        check("midrst_no_done", 32'(done_cnt), 32'(cnt));
        send_frame(8'h7E, 1'b0, 1'b1, -1);

        // Tick enable paused mid-frame.
        send_frame(8'h5A, 1'b0, 1'b1, 70);

        // Break: 346 low ticks give exactly two 0x00 frames with framing errors.
        e.data = 8'h00;
        e.perr = 1'b0;
        e.ferr = 1'b1;
        e.tick = tick_no + 32'd1 + 32'd168;
        exp_q.push_back(e);
        e.tick = tick_no + 32'd1 + 32'd337;
        exp_q.push_back(e);
        for (int i = 0; i < 346; i++) do_tick(1'b0);
        idle_ticks(30);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
